mccpu_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS-subset CPU. It replaces the single-cycle combinational decoder when the datapath is refactored to share one ALU and one unified memory across several cycles per instruction. Each cycle it drives PC/IR/register-file/memory write enables and the mux selects, based on the current state and the decoded Op/Funct/Zero. It sits between the instruction register and the shared datapath.

---
 rtl/mccpu_ctrl_if.sv | 39 +++
 rtl/mccpu_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mccpu_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mccpu_ctrl_if.sv
// Control bundle between the multi-cycle controller and the shared datapath.
// The controller is the master; the datapath/IR side is the slave.
interface mccpu_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemWrite;
  logic       RegWrite;
  logic       EXTOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic [1:0] PCSource;
  logic [1:0] GPRSel;
  logic [1:0] WDSel;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  Op, Funct, Zero,
    output PCWrite, IRWrite, IorD,
    output MemWrite, RegWrite, EXTOp,
    output ALUSrcA, ALUSrcB, ALUOp,
    output PCSource, GPRSel, WDSel,
    output illegal, state
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWrite, IRWrite, IorD,
    input  MemWrite, RegWrite, EXTOp,
    input  ALUSrcA, ALUSrcB, ALUOp,
    input  PCSource, GPRSel, WDSel,
    input  illegal, state
  );
endinterface

// File: rtl/mccpu_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences one shared ALU and one
// unified memory over 2..5 cycles per instruction.
module mccpu_ctrl (
  input  logic         clk,
  input  logic         rst,
  mccpu_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    JR     = 4'd12
  } state_t;

  localparam logic [3:0] A_ADD = 4'b0001;
  localparam logic [3:0] A_SUB = 4'b0010;
  localparam logic [3:0] A_AND = 4'b0011;
  localparam logic [3:0] A_OR  = 4'b0100;
  localparam logic [3:0] A_SLT = 4'b0101;
  localparam logic [3:0] A_SLL = 4'b0110;
  localparam logic [3:0] A_SRL = 4'b0111;
  localparam logic [3:0] A_LUI = 4'b1000;

  state_t cur, nxt;

  logic is_r, is_jr, r_ok, is_shift;
  logic is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_jal, is_addi, is_ori, is_lui;
  logic [3:0] f_alu;

  assign is_r    = bus.Op == 6'b000000;
  assign is_lw   = bus.Op == 6'b100011;
  assign is_sw   = bus.Op == 6'b101011;
  assign is_beq  = bus.Op == 6'b000100;
  assign is_bne  = bus.Op == 6'b000101;
  assign is_j    = bus.Op == 6'b000010;
  assign is_jal  = bus.Op == 6'b000011;
  assign is_addi = bus.Op == 6'b001000;
  assign is_ori  = bus.Op == 6'b001101;
  assign is_lui  = bus.Op == 6'b001111;

  always_comb begin
    f_alu = 4'b0000;
    unique case (bus.Funct)
      6'b100000: f_alu = A_ADD;
      6'b100010: f_alu = A_SUB;
      6'b100100: f_alu = A_AND;
      6'b100101: f_alu = A_OR;
      6'b101010: f_alu = A_SLT;
      6'b000000: f_alu = A_SLL;
      6'b000010: f_alu = A_SRL;
      default:   f_alu = 4'b0000;
    endcase
  end

  // f_alu == 0 marks an unsupported funct (jr handled separately)
  assign is_jr    = is_r && bus.Funct == 6'b001000;
  assign r_ok     = is_r && f_alu != 4'b0000;
  assign is_shift = f_alu == A_SLL || f_alu == A_SRL;

  always_ff @(posedge clk) begin
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  end

  logic       pc_w, ir_w, mem_w, reg_w, ill;
  logic       iord, ext;
  logic [1:0] src_a, src_b, pc_src, gpr, wd;
  logic [3:0] alu;

  always_comb begin
    nxt    = FETCH;
    pc_w   = 1'b0;
    ir_w   = 1'b0;
    mem_w  = 1'b0;
    reg_w  = 1'b0;
    ill    = 1'b0;
    iord   = 1'b0;
    ext    = 1'b0;
    src_a  = 2'd0;
    src_b  = 2'd0;
    pc_src = 2'd0;
    gpr    = 2'd0;
    wd     = 2'd0;
    alu    = 4'b0000;
    unique case (cur)
      FETCH: begin
        ir_w  = 1'b1;
        pc_w  = 1'b1;
        src_b = 2'd1;
        alu   = A_ADD;
        nxt   = DECODE;
      end
      DECODE: begin
        src_b = 2'd3;
        alu   = A_ADD;
        ext   = 1'b1;
        unique case (1'b1)
          is_lw | is_sw:             nxt = MEMADR;
          r_ok:                      nxt = REXEC;
          is_jr:                     nxt = JR;
          is_beq | is_bne:           nxt = BRANCH;
          is_j | is_jal:             nxt = JUMP;
          is_addi | is_ori | is_lui: nxt = IEXEC;
          default: begin
            nxt = FETCH;
            ill = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        src_a = 2'd1;
        src_b = 2'd2;
        ext   = 1'b1;
        alu   = A_ADD;
        if (is_lw)      nxt = MEMRD;
        else if (is_sw) nxt = MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt  = MEMWB;
      end
      MEMWB: begin
        reg_w = 1'b1;
        gpr   = 2'd1;
        wd    = 2'd1;
      end
      MEMWR: begin
        iord  = 1'b1;
        mem_w = 1'b1;
      end
      REXEC: begin
        src_a = is_shift ? 2'd2 : 2'd1;
        alu   = f_alu;
        nxt   = RWB;
      end
      RWB: reg_w = 1'b1;
      BRANCH: begin
        src_a  = 2'd1;
        alu    = A_SUB;
        pc_src = 2'd1;
        pc_w   = is_bne ? ~bus.Zero : bus.Zero;
      end
      JUMP: begin
        pc_src = 2'd2;
        pc_w   = 1'b1;
        if (is_jal) begin
          reg_w = 1'b1;
          gpr   = 2'd2;
          wd    = 2'd2;
        end
      end
      JR: begin
        pc_src = 2'd3;
        pc_w   = 1'b1;
      end
      IEXEC: begin
        src_a = 2'd1;
        src_b = 2'd2;
        nxt   = IWB;
        unique case (1'b1)
          is_ori: alu = A_OR;
          is_lui: alu = A_LUI;
          default: begin
            alu = A_ADD;
            ext = 1'b1;
          end
        endcase
      end
      IWB: begin
        reg_w = 1'b1;
        gpr   = 2'd1;
      end
      default: nxt = FETCH;
    endcase
  end

  // reset aborts the instruction: every write enable is masked that cycle
  assign bus.PCWrite  = pc_w  & ~rst;
  assign bus.IRWrite  = ir_w  & ~rst;
  assign bus.MemWrite = mem_w & ~rst;
  assign bus.RegWrite = reg_w & ~rst;
  assign bus.illegal  = ill   & ~rst;
  assign bus.IorD     = iord;
  assign bus.EXTOp    = ext;
  assign bus.ALUSrcA  = src_a;
  assign bus.ALUSrcB  = src_b;
  assign bus.ALUOp    = alu;
  assign bus.PCSource = pc_src;
  assign bus.GPRSel   = gpr;
  assign bus.WDSel    = wd;
  assign bus.state    = cur;

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Randomized bench for mccpu_ctrl: per-cycle output vector checked
// against a table-driven model of each instruction's state path.
module tb_mccpu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mccpu_ctrl_if bus ();

  mccpu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef enum int {
    C_LW, C_SW, C_R, C_JR, C_BR, C_J, C_I, C_ILL
  } cls_t;

  function automatic cls_t classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100, 6'b000101: return C_BR;
      6'b000010, 6'b000011: return C_J;
      6'b001000, 6'b001101, 6'b001111: return C_I;
      6'b000000: begin
        if (fn == 6'b001000) return C_JR;
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                       6'b101010, 6'b000000, 6'b000010})
          return C_R;
        return C_ILL;
      end
      default: return C_ILL;
    endcase
  endfunction

  function automatic void path(cls_t c, ref int q[$]);
    q = {0, 1};
    case (c)
      C_LW: q = {q, 2, 3, 4};
      C_SW: q = {q, 2, 5};
      C_R:  q = {q, 6, 7};
      C_JR: q.push_back(12);
      C_BR: q.push_back(8);
      C_J:  q.push_back(9);
      C_I:  q = {q, 10, 11};
      default: ;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(logic [5:0] fn);
    case (fn)
      6'b100000: return 4'd1;
      6'b100010: return 4'd2;
      6'b100100: return 4'd3;
      6'b100101: return 4'd4;
      6'b101010: return 4'd5;
      6'b000000: return 4'd6;
      6'b000010: return 4'd7;
      default:   return 4'd0;
    endcase
  endfunction

  // {PCW,IRW,IorD,MemW,RegW,EXT,SrcA,SrcB,ALUOp,PCSrc,GPR,WD,ill,state}
  function automatic logic [31:0] model(int st, logic [5:0] op,
                                        logic [5:0] fn, logic z,
                                        logic in_rst);
    logic pcw, irw, iord, mw, rw, ext, ill;
    logic [1:0] sa, sb, ps, gs, ws;
    logic [3:0] aop;
    {pcw, irw, iord, mw, rw, ext, ill} = '0;
    {sa, sb, ps, gs, ws} = '0;
    aop = 4'd0;
    case (st)
      0: begin irw = 1; pcw = 1; sb = 1; aop = 1; end
      1: begin sb = 3; aop = 1; ext = 1;
               ill = classify(op, fn) == C_ILL; end
      2: begin sa = 1; sb = 2; ext = 1; aop = 1; end
      3: iord = 1;
      4: begin rw = 1; gs = 1; ws = 1; end
      5: begin iord = 1; mw = 1; end
      6: begin
        sa  = (fn == 6'b000000 || fn == 6'b000010) ? 2'd2 : 2'd1;
        aop = r_alu(fn);
      end
      7: rw = 1;
      8: begin sa = 1; aop = 2; ps = 1;
               pcw = (op == 6'b000100) ? z : ~z; end
      9: begin ps = 2; pcw = 1;
               if (op == 6'b000011) begin rw = 1; gs = 2; ws = 2; end
      end
      10: begin
        sa = 1; sb = 2;
        if (op == 6'b001101)      aop = 4;
        else if (op == 6'b001111) aop = 8;
        else begin aop = 1; ext = 1; end
      end
      11: begin rw = 1; gs = 1; end
      12: begin ps = 3; pcw = 1; end
      default: ;
    endcase
    if (in_rst) {pcw, irw, mw, rw, ill} = '0;
    return {7'd0, pcw, irw, iord, mw, rw, ext, sa, sb, aop,
            ps, gs, ws, ill, st[3:0]};
  endfunction

  function automatic logic [31:0] observe();
    return {7'd0, bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemWrite,
            bus.RegWrite, bus.EXTOp, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOp, bus.PCSource, bus.GPRSel, bus.WDSel,
            bus.illegal, bus.state};
  endfunction

  // starts just before the negedge of a FETCH cycle; rst_at < 0 means none
  task automatic run_instr(string tag, logic [5:0] op, logic [5:0] fn,
                           int zmode, int rst_at);
    int q[$];
    path(classify(op, fn), q);
    foreach (q[i]) begin
      @(negedge clk);
      rst = (i == rst_at);
      if (i == 0) begin
        bus.Op    = 6'($urandom);
        bus.Funct = 6'($urandom);
      end else begin
        bus.Op    = op;
        bus.Funct = fn;
      end
      bus.Zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      #1;
      check($sformatf("%s[%0d]", tag, i), observe(),
            model(q[i], op, fn, bus.Zero, rst));
      if (i == rst_at) break;
    end
  endtask

  logic [5:0] legal_op [17] = '{
    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
    6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h0f, 6'h02, 6'h03};
  logic [5:0] legal_fn [17] = '{
    6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02, 6'h08,
    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    logic [5:0] op, fn;
    int k;
    bus.Op = '0;
    bus.Funct = '0;
    bus.Zero = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("reset", observe(), model(0, 6'd0, 6'd0, 1'b0, 1'b1));
    end

    run_instr("lw",   6'b100011, 6'($urandom), -1, -1);
    run_instr("sw",   6'b101011, 6'($urandom), -1, -1);
    run_instr("beqZ", 6'b000100, 6'($urandom), 1, -1);
    run_instr("bneZ", 6'b000101, 6'($urandom), 1, -1);
    run_instr("beqN", 6'b000100, 6'($urandom), 0, -1);
    run_instr("sll",  6'b000000, 6'b000000, -1, -1);
    run_instr("jal",  6'b000011, 6'($urandom), -1, -1);
    run_instr("ill",  6'b111111, 6'($urandom), -1, -1);
    run_instr("lwrst", 6'b100011, 6'd0, -1, 3);
    run_instr("jr",   6'b000000, 6'b001000, -1, -1);

    for (int n = 0; n < 200; n++) begin
      k = int'($urandom_range(0, 19));
      if (k < 17) begin
        op = legal_op[k];
        fn = legal_op[k] == 6'h00 ? legal_fn[k] : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      if ($urandom_range(0, 15) == 0)
        run_instr("rnd_rst", op, fn, -1, int'($urandom_range(0, 4)));
      else
        run_instr("rnd", op, fn, -1, -1);
    end

    run_instr("tail", 6'b001000, 6'd0, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
